stochastic_bitstream_decoder: RTL and testbench

Converts a unipolar stochastic bitstream back to a binary value by counting ones over a fixed window of 2^BITL valid samples. It is the receive end of the stochastic path: the LFSR-driven number generators turn binary probabilities into bitstreams, and this block turns the sampled visible/hidden unit bitstreams back into BITL-bit values for the weight-update logic. It handles one lane; the top level instantiates it once per lane.

---
 rtl/stochastic_bitstream_decoder_pkg.sv | 14 +
 rtl/stochastic_bitstream_decoder_sample_window_counter.sv | 36 +++
 rtl/stochastic_bitstream_decoder.sv | 101 ++++++++++
 tb/tb_stochastic_bitstream_decoder.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/stochastic_bitstream_decoder_pkg.sv
// Shared constants and state encoding for the stochastic bitstream decoder.
// The window length and counter width are derived from the generator width.
package stochastic_bitstream_decoder_pkg;

    localparam int unsigned BITL_DEFAULT = 8;
    localparam int unsigned WINDOW       = 2 ** BITL_DEFAULT;
    localparam int unsigned CNT_W        = BITL_DEFAULT + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

endpackage : stochastic_bitstream_decoder_pkg

// File: rtl/stochastic_bitstream_decoder_sample_window_counter.sv
// Counts accepted samples in a 2^W window and flags the final sample slot.
// Clear has priority over enable; the count wraps to zero after the last slot.
module sample_window_counter #(
    parameter int unsigned W = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic last
);

    logic [W-1:0] sample_cnt_q;
    logic [W-1:0] sample_cnt_d;

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        if (clear) begin
            sample_cnt_d = '0;
        end else if (enable) begin
            sample_cnt_d = sample_cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_cnt_q <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign last = &sample_cnt_q;

endmodule : sample_window_counter

// File: rtl/stochastic_bitstream_decoder.sv
// Decodes one lane of a unipolar stochastic bitstream by counting ones over
// 2^BITL valid samples, clamping a full window to the largest BITL-bit value.
module stochastic_bitstream_decoder
    import stochastic_bitstream_decoder_pkg::*;
#(
    parameter int unsigned BITL = BITL_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            bit_in,
    input  logic            bit_valid,
    output logic            busy,
    output logic [BITL-1:0] data_out,
    output logic            data_valid,
    output logic            saturated
);

    state_e          state_q, state_d;
    logic [BITL:0]   ones_cnt_q, ones_cnt_d;
    logic [BITL-1:0] data_out_q, data_out_d;
    logic            data_valid_q, data_valid_d;
    logic            saturated_q, saturated_d;

    logic            cnt_clear;
    logic            cnt_enable;
    logic            cnt_last;
    logic [BITL:0]   ones_sum;

    sample_window_counter #(
        .W (BITL)
    ) u_sample_window_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .last   (cnt_last)
    );

    // The sum can only reach 2^BITL, so its top bit alone marks a saturated window.
    assign ones_sum = ones_cnt_q + {{BITL{1'b0}}, bit_in};

    // NOTE: every combinational output is defaulted first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        ones_cnt_d   = ones_cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        saturated_d  = saturated_q;
        cnt_clear    = 1'b0;
        cnt_enable   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ACCUM;
                    ones_cnt_d = '0;
                    cnt_clear  = 1'b1;
                end
            end
            ACCUM: begin
                if (start) begin
                    ones_cnt_d = '0;
                    cnt_clear  = 1'b1;
                end else if (bit_valid) begin
                    cnt_enable = 1'b1;
                    ones_cnt_d = ones_sum;
                    if (cnt_last) begin
                        state_d      = IDLE;
                        data_valid_d = 1'b1;
                        saturated_d  = ones_sum[BITL];
                        data_out_d   = ones_sum[BITL] ? {BITL{1'b1}} : ones_sum[BITL-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ones_cnt_q   <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            saturated_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ones_cnt_q   <= ones_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            saturated_q  <= saturated_d;
        end
    end

    assign busy       = (state_q == ACCUM);
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign saturated  = saturated_q;

endmodule : stochastic_bitstream_decoder

// File: tb/tb_stochastic_bitstream_decoder.sv
// Directed self-checking bench for stochastic_bitstream_decoder with BITL=4.
module tb_stochastic_bitstream_decoder;

    localparam int unsigned BITL = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            bit_in;
    logic            bit_valid;
    logic            busy;
    logic [BITL-1:0] data_out;
    logic            data_valid;
    logic            saturated;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    stochastic_bitstream_decoder #(
        .BITL (BITL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid),
        .saturated  (saturated)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, observe 1 time unit after the rising edge.
    task automatic step(input logic s, input logic v, input logic b);
        @(negedge clk);
        start     = s;
        bit_valid = v;
        bit_in    = b;
        @(posedge clk);
        #1;
        if (data_valid === 1'b1) pulses++;
        start     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    // Feeds 16 valid samples (bits[i] is sample i), optionally with two invalid
    // cycles carrying bit_in=1 before each, then checks the completion cycle.
    task automatic run_window(input string tag, input logic [15:0] bits, input bit gapped,
                              input logic [BITL-1:0] exp_out, input logic exp_sat);
        int early = pulses;
        for (int i = 0; i < 16; i++) begin
            if (gapped) begin
                step(1'b0, 1'b0, 1'b1);
                step(1'b0, 1'b0, 1'b1);
            end
            if (i == 15) check({tag, "_no_early_valid"}, pulses - early, 0);
            step(1'b0, 1'b1, bits[i]);
        end
        check({tag, "_valid"}, data_valid, 1'b1);
        check({tag, "_busy_low"}, busy, 1'b0);
        check({tag, "_data_out"}, data_out, exp_out);
        check({tag, "_saturated"}, saturated, exp_sat);
    endtask

    initial begin
        int base;
        reset     = 1'b0;
        start     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_data_out", data_out, 0);
        check("rst_valid", data_valid, 1'b0);
        check("rst_sat", saturated, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // 1: full window of ones clamps to 15
        step(1'b1, 1'b1, 1'b1);
        check("t1_busy", busy, 1'b1);
        run_window("t1", 16'hFFFF, 1'b0, 4'd15, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("t1_pulse_one_cycle", data_valid, 1'b0);
        check("t1_data_held", data_out, 15);
        check("t1_sat_held", saturated, 1'b1);

        // 2: alternating, then all zeros
        step(1'b1, 1'b0, 1'b0);
        run_window("t2a", 16'h5555, 1'b0, 4'd8, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        run_window("t2b", 16'h0000, 1'b0, 4'd0, 1'b0);

        // 3: valid every third cycle, invalid cycles carry ones
        step(1'b1, 1'b0, 1'b0);
        run_window("t3", 16'h001F, 1'b1, 4'd5, 1'b0);

        // 4: restart mid-window with a valid one presented alongside start
        base = pulses;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("t4_restart_busy", busy, 1'b1);
        run_window("t4", 16'h0124, 1'b0, 4'd3, 1'b0);
        check("t4_single_pulse", pulses - base, 1);

        // 5: start in the data_valid cycle chains the next conversion
        base = pulses;
        step(1'b1, 1'b0, 1'b0);
        run_window("t5a", 16'h01FF, 1'b0, 4'd9, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("t5_chain_busy", busy, 1'b1);
        check("t5_first_held", data_out, 9);
        run_window("t5b", 16'h0FFF, 1'b0, 4'd12, 1'b0);
        check("t5_two_pulses", pulses - base, 2);

        // 6: asynchronous reset mid-window
        base = pulses;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_busy", busy, 1'b0);
        check("t6_data_out", data_out, 0);
        check("t6_sat", saturated, 1'b0);
        check("t6_valid", data_valid, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        check("t6_no_pulse", pulses - base, 0);
        step(1'b1, 1'b0, 1'b0);
        run_window("t6", 16'h1111, 1'b0, 4'd4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got %0d checks expected completion", checks);
        $fatal(1, "timeout");
    end

endmodule : tb_stochastic_bitstream_decoder
